// File: rtl/sm_sum_table_builder_pkg.sv
// Shared definitions for the sign-magnitude sum table builder.
// Holds the FSM state encoding, the table-depth helper and the
// sign-magnitude adder used to generate table entries.
// Optional build macro: SM_TABLE_SATURATE_EN (saturate instead of wrap on overflow).
package sm_table_pkg;

  // Operand width the adder function is built for; the top's DATA_WIDTH follows it.
  localparam int SM_DW = 4;
  // Magnitude width (sign bit excluded).
  localparam int SM_MW = SM_DW - 1;

  typedef logic [SM_DW-1:0] sm_word_t;
  // Table entry layout: {ovf, sign, magnitude}.
  typedef logic [SM_DW:0]   sm_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } sm_state_e;

  // Table depth for a given operand width: one entry per {a, b} pair.
  function automatic int unsigned sm_table_depth(input int unsigned dw);
    return 32'd1 << (2 * dw);
  endfunction

  // Sign-magnitude addition returning {ovf, sum}; zero results are always +0.
  function automatic sm_entry_t sm_add(input sm_word_t a, input sm_word_t b);
    logic [SM_MW-1:0] ma;
    logic [SM_MW-1:0] mb;
    logic [SM_MW-1:0] mag;
    logic [SM_MW:0]   s;
    logic             sgn;
    logic             ovf;
    ma  = a[SM_MW-1:0];
    mb  = b[SM_MW-1:0];
    ovf = 1'b0;
    s   = '0;
    if (a[SM_MW] == b[SM_MW]) begin
      s   = {1'b0, ma} + {1'b0, mb};
      ovf = s[SM_MW];
      sgn = a[SM_MW];
`ifdef SM_TABLE_SATURATE_EN
      mag = ovf ? {SM_MW{1'b1}} : s[SM_MW-1:0];
`else
      mag = s[SM_MW-1:0];
`endif
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = a[SM_MW];
    end else begin
      mag = mb - ma;
      sgn = b[SM_MW];
    end
    // Canonical zero: covers -0 operands, cancellation and a wrap to zero.
    if (mag == '0) sgn = 1'b0;
    return {ovf, sgn, mag};
  endfunction

endpackage

// File: rtl/sm_sum_table_builder_if.sv
// Control and lookup bundle for sm_sum_table_builder.
// master: the client issuing start/lookups; slave: the table builder.
interface sm_sum_table_builder_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  start;
  logic                  busy;
  logic                  ready;
  logic                  fill_done;
  logic                  lk_en;
  logic [DATA_WIDTH-1:0] lk_a;
  logic [DATA_WIDTH-1:0] lk_b;
  logic                  lk_valid;
  logic [DATA_WIDTH-1:0] lk_sum;
  logic                  lk_ovf;

  modport master (
    output start, lk_en, lk_a, lk_b,
    input  busy, ready, fill_done, lk_valid, lk_sum, lk_ovf
  );

  modport slave (
    input  start, lk_en, lk_a, lk_b,
    output busy, ready, fill_done, lk_valid, lk_sum, lk_ovf
  );
endinterface

// File: rtl/sm_sum_table_builder_ram.sv
// Simple dual-port table RAM: synchronous write, registered synchronous read.
// Contents and read register are not reset so the array maps onto block RAM.
module sm_table_ram #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH:0]   i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH:0]   o_rdata
);
  logic [DATA_WIDTH:0] r_mem [2**ADDR_W];
  logic [DATA_WIDTH:0] r_rdata;

  // Write port: one entry per enabled cycle.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: data registered only on a read so it holds between reads.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/sm_sum_table_builder.sv
// Sign-magnitude sum table builder. On start, sweeps every {a, b} pair,
// writes {ovf, sum} into the table RAM one entry per cycle, then serves
// one-cycle-latency lookups while READY.
// Optional build macro: SM_TABLE_SATURATE_EN (handled inside sm_table_pkg::sm_add).
module sm_sum_table_builder
  import sm_table_pkg::*;
#(
  // Must equal sm_table_pkg::SM_DW, which sizes the adder function.
  parameter int DATA_WIDTH = SM_DW
) (
  input logic                    clk,
  input logic                    rst_n,
  sm_sum_table_builder_if.slave  bus
);
  localparam int          ADDR_W = 2 * DATA_WIDTH;
  localparam int unsigned DEPTH  = sm_table_depth(DATA_WIDTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_FILL  = FILL;
  localparam logic [1:0] S_READY = READY;

  logic [1:0]          r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_lk_valid;
  logic                r_rd_seen;

  logic                w_fill;
  logic                w_rd;
  logic [DATA_WIDTH:0] w_wdata;
  logic [DATA_WIDTH:0] w_rdata;

  assign w_fill  = (r_state == S_FILL);
  // Lookups are only honoured once the table is complete.
  assign w_rd    = bus.lk_en && (r_state == S_READY);
  // Entry for the current sweep address; address layout is {a, b}.
  assign w_wdata = sm_add(SM_DW'(r_addr[ADDR_W-1:DATA_WIDTH]),
                          SM_DW'(r_addr[DATA_WIDTH-1:0]));

  // Fill sequencer: IDLE/READY -> FILL on start, FILL -> READY after the last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_FILL;
            r_addr  <= '0;
          end
        end
        S_FILL: begin
          if (r_addr == LAST_ADDR) begin
            r_state <= S_READY;
            r_addr  <= '0;
          end else begin
            r_addr  <= r_addr + 1'b1;
          end
        end
        S_READY: begin
          if (bus.start) begin
            r_state <= S_FILL;
            r_addr  <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_addr  <= '0;
        end
      endcase
    end
  end

  // Lookup valid tracking; r_rd_seen masks the unreset RAM output until the first read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lk_valid <= 1'b0;
      r_rd_seen  <= 1'b0;
    end else begin
      r_lk_valid <= w_rd;
      r_rd_seen  <= r_rd_seen | w_rd;
    end
  end

  sm_table_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_fill),
    .i_waddr (r_addr),
    .i_wdata (w_wdata),
    .i_re    (w_rd),
    .i_raddr ({bus.lk_a, bus.lk_b}),
    .o_rdata (w_rdata)
  );

  assign bus.busy      = w_fill;
  assign bus.ready     = (r_state == S_READY);
  assign bus.fill_done = w_fill && (r_addr == LAST_ADDR);
  assign bus.lk_valid  = r_lk_valid;
  assign bus.lk_sum    = r_rd_seen ? w_rdata[DATA_WIDTH-1:0] : '0;
  assign bus.lk_ovf    = r_rd_seen ? w_rdata[DATA_WIDTH]     : 1'b0;
endmodule

// File: tb/tb_sm_sum_table_builder.sv
// Directed bench for sm_sum_table_builder (DATA_WIDTH = 4): fill timing,
// lookups, zero canonicalisation, overflow, lookup gating, rebuild and
// mid-fill reset. Expected values follow SM_TABLE_SATURATE_EN if defined.
module tb_sm_sum_table_builder;
  localparam int DW = 4;
  localparam int N  = 256;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  sm_sum_table_builder_if #(.DATA_WIDTH(DW)) bus ();

  sm_sum_table_builder #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("assertion %s", tag);
    end
  endtask

  // Lookup vectors: a, b, expected sum, expected ovf.
  logic [3:0] va [10];
  logic [3:0] vb [10];
  logic [3:0] vs [10];
  logic       vo [10];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    va[0] = 4'b0011; vb[0] = 4'b0010; vs[0] = 4'b0101; vo[0] = 1'b0;
    va[1] = 4'b1011; vb[1] = 4'b0010; vs[1] = 4'b1001; vo[1] = 1'b0;
    va[2] = 4'b0010; vb[2] = 4'b1101; vs[2] = 4'b1011; vo[2] = 1'b0;
    va[3] = 4'b1101; vb[3] = 4'b0101; vs[3] = 4'b0000; vo[3] = 1'b0;
    va[4] = 4'b1000; vb[4] = 4'b1000; vs[4] = 4'b0000; vo[4] = 1'b0;
    va[5] = 4'b1111; vb[5] = 4'b0111; vs[5] = 4'b0000; vo[5] = 1'b0;
    va[6] = 4'b0001; vb[6] = 4'b1011; vs[6] = 4'b1010; vo[6] = 1'b0;
`ifdef SM_TABLE_SATURATE_EN
    va[7] = 4'b0111; vb[7] = 4'b0001; vs[7] = 4'b0111; vo[7] = 1'b1;
    va[8] = 4'b1110; vb[8] = 4'b1011; vs[8] = 4'b1111; vo[8] = 1'b1;
    va[9] = 4'b0101; vb[9] = 4'b0101; vs[9] = 4'b0111; vo[9] = 1'b1;
`else
    va[7] = 4'b0111; vb[7] = 4'b0001; vs[7] = 4'b0000; vo[7] = 1'b1;
    va[8] = 4'b1110; vb[8] = 4'b1011; vs[8] = 4'b1001; vo[8] = 1'b1;
    va[9] = 4'b0101; vb[9] = 4'b0101; vs[9] = 4'b0010; vo[9] = 1'b1;
`endif

    // Reset state
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.lk_en = 1'b0;
    bus.lk_a  = '0;
    bus.lk_b  = '0;
    step();
    step();
    check("rst_busy",      8'(bus.busy),      8'd0);
    check("rst_ready",     8'(bus.ready),     8'd0);
    check("rst_fill_done", 8'(bus.fill_done), 8'd0);
    check("rst_lk_valid",  8'(bus.lk_valid),  8'd0);
    check("rst_lk_sum",    8'(bus.lk_sum),    8'd0);
    check("rst_lk_ovf",    8'(bus.lk_ovf),    8'd0);
    rst_n = 1'b1;
    step();

    // Lookups in IDLE are ignored
    bus.lk_en = 1'b1;
    bus.lk_a  = 4'b0011;
    bus.lk_b  = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_lk_valid", 8'(bus.lk_valid), 8'd0);
      check("idle_busy",     8'(bus.busy),     8'd0);
    end

    // Fill with lk_en held high and a stray start mid-fill
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= N; i++) begin
      bus.start = 1'b0;
      check("fill_busy",      8'(bus.busy),      8'd1);
      check("fill_ready",     8'(bus.ready),     8'd0);
      check("fill_lk_valid",  8'(bus.lk_valid),  8'd0);
      check("fill_done",      8'(bus.fill_done), (i == N) ? 8'd1 : 8'd0);
      if (i == 50) bus.start = 1'b1;
      step();
    end
    check("ready_after_fill", 8'(bus.ready),     8'd1);
    check("busy_after_fill",  8'(bus.busy),      8'd0);
    check("done_after_fill",  8'(bus.fill_done), 8'd0);
    check("lk_valid_257",     8'(bus.lk_valid),  8'd0);
    bus.lk_en = 1'b0;
    step();

    // Back-to-back lookups
    for (int j = 0; j < 10; j++) begin
      bus.lk_en = 1'b1;
      bus.lk_a  = va[j];
      bus.lk_b  = vb[j];
      step();
      check($sformatf("lk_valid_%0d", j), 8'(bus.lk_valid), 8'd1);
      check($sformatf("lk_sum_%0d", j),   8'(bus.lk_sum),   8'(vs[j]));
      check($sformatf("lk_ovf_%0d", j),   8'(bus.lk_ovf),   8'(vo[j]));
    end
    bus.lk_en = 1'b0;
    bus.lk_a  = 4'b0011;
    bus.lk_b  = 4'b0010;
    step();
    check("hold_valid", 8'(bus.lk_valid), 8'd0);
    check("hold_sum",   8'(bus.lk_sum),   8'(vs[9]));
    check("hold_ovf",   8'(bus.lk_ovf),   8'(vo[9]));

    // Rebuild from READY with a lookup on the start cycle
    bus.start = 1'b1;
    bus.lk_en = 1'b1;
    bus.lk_a  = 4'b0011;
    bus.lk_b  = 4'b0010;
    step();
    bus.start = 1'b0;
    bus.lk_en = 1'b0;
    check("rebuild_lk_valid", 8'(bus.lk_valid), 8'd1);
    check("rebuild_lk_sum",   8'(bus.lk_sum),   8'b0101);
    check("rebuild_ready",    8'(bus.ready),    8'd0);
    check("rebuild_busy",     8'(bus.busy),     8'd1);
    for (int i = 1; i < N; i++) step();
    check("rebuild_done",     8'(bus.fill_done), 8'd1);
    step();
    check("rebuild_ready_up", 8'(bus.ready),     8'd1);

    // Reset asserted at fill cycle 100
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 100; i++) step();
    check("pre_rst_busy", 8'(bus.busy), 8'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",      8'(bus.busy),      8'd0);
    check("mid_rst_ready",     8'(bus.ready),     8'd0);
    check("mid_rst_fill_done", 8'(bus.fill_done), 8'd0);
    check("mid_rst_lk_valid",  8'(bus.lk_valid),  8'd0);
    check("mid_rst_lk_sum",    8'(bus.lk_sum),    8'd0);
    check("mid_rst_lk_ovf",    8'(bus.lk_ovf),    8'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("post_rst_idle_busy",  8'(bus.busy),  8'd0);
    check("post_rst_idle_ready", 8'(bus.ready), 8'd0);

    // Fresh full fill after reset, then a lookup
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("refill_busy_1", 8'(bus.busy), 8'd1);
    for (int i = 1; i < N; i++) step();
    check("refill_busy_256", 8'(bus.busy),      8'd1);
    check("refill_done_256", 8'(bus.fill_done), 8'd1);
    step();
    check("refill_ready_257", 8'(bus.ready), 8'd1);
    bus.lk_en = 1'b1;
    bus.lk_a  = va[9];
    bus.lk_b  = vb[9];
    step();
    bus.lk_en = 1'b0;
    check("refill_lk_valid", 8'(bus.lk_valid), 8'd1);
    check("refill_lk_sum",   8'(bus.lk_sum),   8'(vs[9]));
    check("refill_lk_ovf",   8'(bus.lk_ovf),   8'(vo[9]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sm_sum_table_builder.md
# sm_sum_table_builder

Builds and serves a RAM-resident lookup table of sign-magnitude sums. On a start pulse, an FSM sweeps every operand pair {a, b}, computes the sign-magnitude sum and writes it into an internal table RAM, one entry per cycle. Once the table is filled, the lookup port returns any sum with one cycle of read latency. This block is the writer/producer for the memory-based sign-magnitude adder datapath in the Memory_FPGA design.

## Interface
- DATA_WIDTH, 4, operand/result width; MSB is sign, low DATA_WIDTH-1 bits are magnitude
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to (re)build the table
- busy  out  1  high while filling
- ready  out  1  high once the table is complete and valid
- fill_done  out  1  one-cycle pulse on the last table write
- lk_en  in  1  lookup request
- lk_a  in  DATA_WIDTH  lookup operand a
- lk_b  in  DATA_WIDTH  lookup operand b
- lk_valid  out  1  lk_sum/lk_ovf valid this cycle
- lk_sum  out  DATA_WIDTH  sign-magnitude sum
- lk_ovf  out  1  magnitude overflow flag for the entry

## Operation
- Table depth N = 2^(2*DATA_WIDTH), address = {a, b}, entry = {ovf, sum} (DATA_WIDTH+1 bits).
- FSM states:
  - IDLE -> FILL on start.
  - FILL increments the address counter from 0 to N-1, writing one entry per cycle; FILL -> READY after writing N-1.
  - READY -> FILL on start (rebuild).
- start is ignored in FILL.
- Sum rule, using magnitudes ma, mb (DATA_WIDTH-1 bits):
  - Equal signs: magnitude = ma+mb, sign = common sign.
  - Differing signs: magnitude = |ma-mb|, sign = sign of the larger magnitude.
- Zero is canonical: any zero-magnitude result has sign 0. Covers -0 inputs and equal magnitudes with opposite signs.
- ovf = 1 when an equal-sign add carries out of DATA_WIDTH-1 bits.
- Lookups are accepted only in READY. lk_en in IDLE or FILL produces no lk_valid and no read.
- Table RAM contents are not reset. Validity is carried only by ready.

## Timing
- Reset values: busy=0, ready=0, fill_done=0, lk_valid=0, lk_sum=0, lk_ovf=0. State is IDLE and the counter is 0.
- start sampled high at edge k:
  - busy=1 from cycle k+1.
  - Writes to addresses 0..N-1 occur in cycles k+1..k+N.
  - fill_done pulses in cycle k+N.
  - busy=0 and ready=1 from cycle k+N+1.
- A rebuild from READY drops ready in the cycle after start is sampled. A lookup issued on the start cycle still completes.
- Lookup latency is 1 cycle: lk_en sampled at edge k gives lk_valid=1 with data in cycle k+1. Back-to-back lookups run at full rate. lk_sum/lk_ovf hold their last value when lk_valid=0.
- Reset asserted mid-fill: the FSM returns to IDLE immediately and ready=0. A new start is required.

## Configuration
- SM_TABLE_SATURATE_EN defined: on overflow, the magnitude saturates to all-ones (2^(DATA_WIDTH-1)-1) and the sign is preserved.
- SM_TABLE_SATURATE_EN undefined: on overflow, the magnitude wraps modulo 2^(DATA_WIDTH-1). If the wrapped magnitude is 0, the sign is 0.
- ovf is reported identically in both builds.

## Structure
- Package sm_table_pkg holds:
  - state enum (IDLE, FILL, READY)
  - sm_add function returning {ovf, sum}, with the saturation behaviour selected by SM_TABLE_SATURATE_EN
  - localparam helper for table depth
- Sub-module sm_table_ram: simple dual-port RAM, depth N, width DATA_WIDTH+1. Synchronous write port and registered synchronous read port, with no reset on contents. Inferable as block RAM.

## Test plan
- Fill timing, DATA_WIDTH=4: start at cycle 0 -> busy cycles 1..256, fill_done in cycle 256, ready=1 at cycle 257.
- Lookups after ready:
  - 0011+0010 -> 0101, ovf=0.
  - 1011+0010 -> 1001.
  - 0010+1101 -> 1011.
- Zero canonicalisation:
  - 1101+0101 -> 0000.
  - 1000+1000 -> 0000, ovf=0.
- Overflow, 0111+0001:
  - With SM_TABLE_SATURATE_EN: 0111, ovf=1.
  - Without it: 0000, ovf=1.
  - 1110+1011 -> 1111 saturated or 1001 wrapped, ovf=1.
- lk_en held high during IDLE and FILL -> lk_valid stays 0. A start pulse during FILL does not restart the fill: ready still rises at cycle 257.
- rst_n low at fill cycle 100 -> all outputs at reset values and state IDLE. A new start gives a full 256-cycle fill, then a correct lookup of 0101+0101 -> 0111 with ovf=1 (saturated build).
